ifetch_unit: RTL and testbench

Instruction fetch initiator for the RISC-V core. It owns the program counter and drives word addresses into the combinational instruction memory. Each returned word is captured, together with its PC, into a 2-entry buffer that feeds decode over a valid/ready handshake. Branch and jump redirects flush the buffer, and a misaligned redirect target raises a fetch fault instead of ever issuing a misaligned address to memory.

---
 rtl/rv_fetch_pkg.sv | 18 +
 rtl/fetch_buf2.sv | 61 ++++++
 rtl/ifetch_unit.sv | 92 +++++++++
 tb/tb_ifetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package rv_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry in-order FIFO with flush; head is driven straight from storage.
module fetch_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = rd_ptr ? mem1 : mem0;

    // A flush may carry one fresh entry, which lands in slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= push;
            count  <= {1'b0, push};
            if (push) begin
                mem0 <= din;
            end
        end else begin
            if (do_push) begin
                if (wr_ptr) begin
                    mem1 <= din;
                end else begin
                    mem0 <= din;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch initiator: owns the PC, feeds a 2-entry buffer toward decode, handles redirects.
//   state    | meaning
//   ST_RUN   | fetching sequentially whenever the buffer has room
//   ST_FAULT | misaligned redirect seen; no fetch until the next redirect
module ifetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC          = RESET_PC_DEFAULT,
    parameter int          INST_WIDTH_LENGTH = 32,
    parameter int          PC_WIDTH_LENGTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH_LENGTH-1:0]   PC,
    input  logic [INST_WIDTH_LENGTH-1:0] inst,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    output logic                         if_valid,
    input  logic                         if_ready,
    output logic [INST_WIDTH_LENGTH-1:0] if_inst,
    output logic [PC_WIDTH_LENGTH-1:0]   if_pc,
    output logic                         if_fault
);

    localparam int ENTRY_W = $bits(fetch_entry_t);

    fetch_state_t                 state;
    logic [PC_WIDTH_LENGTH-1:0]   fetch_pc;
    logic [1:0]                   count;
    logic [ENTRY_W-1:0]           head_bits;
    fetch_entry_t                 head_entry;
    fetch_entry_t                 push_entry;
    logic                         misaligned;
    logic                         pop;
    logic                         fire;
    logic                         push;

    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // A redirect cycle never consumes the head, even with if_ready high.
    assign pop        = if_valid && if_ready && !redirect_valid;
    assign fire       = (state == ST_RUN) && !redirect_valid &&
                        ((count != 2'd2) || pop);
    assign push       = fire || misaligned;

    always_comb begin
        push_entry = '0;
        if (misaligned) begin
            push_entry.pc    = redirect_pc;
            push_entry.fault = 1'b1;
        end else begin
            push_entry.inst  = inst;
            push_entry.pc    = fetch_pc;
        end
    end

    fetch_buf2 #(
        .WIDTH (ENTRY_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .count (count),
        .head  (head_bits)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            if (misaligned) begin
                state <= ST_FAULT;
            end else begin
                state    <= ST_RUN;
                fetch_pc <= redirect_pc;
            end
        end else if (fire) begin
            fetch_pc <= fetch_pc + PC_WIDTH_LENGTH'(PC_STEP);
        end
    end

    assign head_entry = fetch_entry_t'(head_bits);
    assign PC         = fetch_pc;
    assign if_valid   = (count != 2'd0);
    assign if_fault   = if_valid && head_entry.fault;
    assign if_pc      = if_valid ? head_entry.pc : '0;
    assign if_inst    = (if_valid && !head_entry.fault) ? head_entry.inst : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a queue-based fetch model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_fault;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_fault_mode;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [31:0] addr);
        return 32'h0000_0013 + (addr >> 2);
    endfunction

    assign inst = mem_word(PC);

    ifetch_unit #(
        .RESET_PC          (32'h0000_0000),
        .INST_WIDTH_LENGTH (32),
        .PC_WIDTH_LENGTH   (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc         = 32'h0000_0000;
        m_fault_mode = 1'b0;
    endtask

    task automatic check_outputs();
        logic        v;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        ef;
        v     = (mq.size() > 0);
        epc   = v ? mq[0].pc : 32'h0;
        ef    = v ? mq[0].fault : 1'b0;
        einst = (v && !ef) ? mq[0].inst : 32'h0;
        check("PC", PC, m_pc);
        check("if_valid", {31'b0, if_valid}, {31'b0, v});
        check("if_pc", if_pc, epc);
        check("if_inst", if_inst, einst);
        check("if_fault", {31'b0, if_fault}, {31'b0, ef});
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(bit rv, logic [31:0] rpc, bit rdy);
        bit pop;
        bit fire;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        if (rv) begin
            mq.delete();
            if (rpc[1:0] == 2'b00) begin
                m_pc         = rpc;
                m_fault_mode = 1'b0;
            end else begin
                m_fault_mode = 1'b1;
                mq.push_back('{inst: 32'h0, pc: rpc, fault: 1'b1});
            end
        end else begin
            pop  = (mq.size() > 0) && rdy;
            fire = !m_fault_mode && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (fire) begin
                mq.push_back('{inst: mem_word(m_pc), pc: m_pc, fault: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_PC", PC, 32'h0);
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_if_fault", {31'b0, if_fault}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Streaming with decode always ready
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // Backpressure from reset
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
        check("bp_PC_frozen", PC, 32'h0000_0008);
        check("bp_head_pc", if_pc, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // Fill, then redirect with if_ready high
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b1);
        check("redir_N1_PC", PC, 32'h0000_0100);
        step(1'b0, 32'h0, 1'b1);
        check("redir_N2_pc", if_pc, 32'h0000_0100);
        step(1'b0, 32'h0, 1'b1);

        // Misaligned redirect, drain fault, stay idle, then recover
        step(1'b1, 32'h0000_0102, 1'b0);
        check("mis_fault", {31'b0, if_fault}, 32'h1);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        // Wrap-around
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("wrap_pc", if_pc, 32'h0000_0000);
        step(1'b0, 32'h0, 1'b1);

        // Async reset mid-stream
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: rpc = $urandom() & 32'hFFFF_FFFC;
                    1: rpc = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(3, 1));
                    2: rpc = 32'hFFFF_FFF8;
                    default: rpc = 32'h0000_0100;
                endcase
                step(1'b1, rpc, $urandom_range(1) == 1);
            end else begin
                step(1'b0, 32'h0, $urandom_range(3) != 0);
            end
            if (i == 300) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
